// File: rtl/sonic_ranger_multi_if.sv
// Signal bundle between the multi-channel ranger and its sensors / result consumers.
interface sonic_ranger_multi_if #(
    parameter int N_CH   = 2,
    parameter int DIST_W = 16
) ();
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     en;
    logic [N_CH-1:0]          echo;
    logic [N_CH-1:0]          trig;
    logic [N_CH*DIST_W-1:0]   distance;
    logic [N_CH-1:0]          valid;
    logic [N_CH-1:0]          timeout;
    logic                     upd_stb;
    logic [CH_W-1:0]          upd_ch;

    modport master (
        input  en, echo,
        output trig, distance, valid, timeout, upd_stb, upd_ch
    );

    modport slave (
        output en, echo,
        input  trig, distance, valid, timeout, upd_stb, upd_ch
    );
endinterface

// File: rtl/sonic_ranger_multi.sv
// Round-robin HC-SR04 ranger: one time-shared FSM triggers each sensor in its own slot,
// times the echo on a clk-derived microsecond tick and stores millimetre results per channel.
module sonic_ranger_multi #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int N_CH       = 2,
    parameter int TRIG_US    = 10,
    parameter int SLOT_MS    = 60,
    parameter int TIMEOUT_US = 30000,
    parameter int DIST_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sonic_ranger_multi_if.master bus
);
    localparam int CYC_US   = CLK_HZ / 1_000_000;
    localparam int TRIG_CYC = TRIG_US * CYC_US;
    localparam int SLOT_CYC = SLOT_MS * 1000 * CYC_US;
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PRE_W    = (CYC_US > 1) ? $clog2(CYC_US) : 1;
    localparam int US_W     = $clog2(TIMEOUT_US + 1);
    localparam int SLOT_W   = $clog2(SLOT_CYC + 1);
    localparam int PROD_W   = US_W + 4;
    localparam int Q_W      = (PROD_W > DIST_W) ? PROD_W : DIST_W;
    localparam logic [Q_W-1:0] DIST_MAX = Q_W'({DIST_W{1'b1}});

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TRIG      = 3'd1;
    localparam logic [2:0] WAIT_RISE = 3'd2;
    localparam logic [2:0] MEASURE   = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;

    logic [2:0]             state;
    logic [CH_W-1:0]        ch;
    logic [SLOT_W-1:0]      slot_cnt;
    logic [PRE_W-1:0]       pre_cnt;
    logic [US_W-1:0]        us_cnt;
    logic                   res_to;
    logic [N_CH-1:0]        echo_s1, echo_s2, echo_d;
    logic [N_CH-1:0]        trig_q, valid_q, timeout_q;
    logic [N_CH*DIST_W-1:0] dist_q;
    logic                   upd_stb_q;
    logic [CH_W-1:0]        upd_ch_q;

    // NOTE: echo is asynchronous, so it passes through two flops before any logic looks at it;
    // echo_d is the one-cycle-delayed copy used only for edge detection.
    // NOTE: every register is assigned with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_d  <= '0;
        end else begin
            echo_s1 <= bus.echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    logic echo_rise, echo_fall, us_tick, us_limit;
    assign echo_rise = echo_s2[ch] & ~echo_d[ch];
    assign echo_fall = ~echo_s2[ch] & echo_d[ch];
    assign us_tick   = (pre_cnt == PRE_W'(CYC_US - 1));
    // The counter is about to reach TIMEOUT_US on this edge.
    assign us_limit  = us_tick && (us_cnt >= US_W'(TIMEOUT_US - 1));

    logic [Q_W-1:0]    prod, quot;
    logic [DIST_W-1:0] dist_new;

    // NOTE: dist_new gets a value on every path so no latch is inferred.
    always_comb begin
        prod = Q_W'(us_cnt) * Q_W'(10);
        quot = prod / Q_W'(58);
        if (res_to || (quot > DIST_MAX)) dist_new = '1;
        else                             dist_new = quot[DIST_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            slot_cnt  <= '0;
            pre_cnt   <= '0;
            us_cnt    <= '0;
            res_to    <= 1'b0;
            trig_q    <= '0;
            dist_q    <= '0;
            valid_q   <= '0;
            timeout_q <= '0;
            upd_stb_q <= 1'b0;
            upd_ch_q  <= '0;
        end else begin
            upd_stb_q <= 1'b0;
            if (slot_cnt != SLOT_W'(SLOT_CYC)) slot_cnt <= slot_cnt + 1'b1;
            if (state == WAIT_RISE || state == MEASURE) begin
                pre_cnt <= us_tick ? '0 : pre_cnt + 1'b1;
                if (us_tick && us_cnt != US_W'(TIMEOUT_US)) us_cnt <= us_cnt + 1'b1;
            end

            case (state)
                IDLE: if (bus.en) begin
                    // slot_cnt counts the trigger-rise edge itself as cycle 1.
                    slot_cnt <= SLOT_W'(1);
                    trig_q   <= N_CH'(1) << ch;
                    state    <= TRIG;
                end
                TRIG: if (slot_cnt == SLOT_W'(TRIG_CYC)) begin
                    trig_q  <= '0;
                    pre_cnt <= '0;
                    us_cnt  <= '0;
                    state   <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (echo_rise) begin
                        pre_cnt <= '0;
                        us_cnt  <= '0;
                        state   <= MEASURE;
                    end else if (us_limit) begin
                        res_to <= 1'b1;
                        state  <= DONE;
                    end
                end
                MEASURE: begin
                    if (echo_fall) begin
                        res_to <= 1'b0;
                        state  <= DONE;
                    end else if (us_limit) begin
                        res_to <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    dist_q[ch*DIST_W +: DIST_W] <= dist_new;
                    valid_q[ch]   <= ~res_to;
                    timeout_q[ch] <= res_to;
                    upd_stb_q     <= 1'b1;
                    upd_ch_q      <= ch;
                    state         <= GAP;
                end
                GAP: begin
                    // Exits one cycle early so IDLE lands the next trigger exactly one slot later;
                    // an already-expired slot leaves immediately.
                    if (slot_cnt >= SLOT_W'(SLOT_CYC - 1)) begin
                        ch    <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.trig     = trig_q;
    assign bus.distance = dist_q;
    assign bus.valid    = valid_q;
    assign bus.timeout  = timeout_q;
    assign bus.upd_stb  = upd_stb_q;
    assign bus.upd_ch   = upd_ch_q;
endmodule

// File: tb/tb_sonic_ranger_multi.sv
// Directed bench for sonic_ranger_multi at 2 MHz, 2 channels, 5 ms slots, 3000 us timeout.
module tb_sonic_ranger_multi;
    localparam int N_CH   = 2;
    localparam int DIST_W = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    sonic_ranger_multi_if #(.N_CH(N_CH), .DIST_W(DIST_W)) bus ();

    sonic_ranger_multi #(
        .CLK_HZ(2_000_000), .N_CH(N_CH), .TRIG_US(10), .SLOT_MS(5),
        .TIMEOUT_US(3000), .DIST_W(DIST_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #250 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Distances may differ by 1 mm because the echo is sampled on the microsecond tick.
    task automatic check_near(input string tag, input int obs, input int exp);
        checks++;
        assert (obs >= exp - 1 && obs <= exp + 1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+-1", tag, obs, exp);
        end
    endtask

    task automatic wait_trig(input int k, input logic lvl, input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.trig[k] === lvl) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_upd(input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.upd_stb === 1'b1) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic pulse_echo(input int k, input int cycles);
        bus.echo[k] = 1'b1;
        repeat (cycles) @(negedge clk);
        bus.echo[k] = 1'b0;
    endtask

    initial begin
        int   t0, t1, tw, tx;
        logic seen;

        rst     = 1'b1;
        bus.en  = 1'b1;
        bus.echo = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({bus.trig, bus.valid, bus.timeout, bus.upd_stb, bus.upd_ch}), 32'd0);
        check("reset_dist", 32'(bus.distance), 32'd0);
        rst = 1'b0;

        // Slot ch0: trigger width, 580 us echo with crosstalk on ch1.
        wait_trig(0, 1'b1, 5, "trig0_rise");
        t0 = cyc;
        check("trig_onehot_ch0", 32'(bus.trig), 32'd1);
        wait_trig(0, 1'b0, 40, "trig0_fall");
        check("trig0_width", 32'(cyc - t0), 32'd20);
        repeat (100) @(negedge clk);
        bus.echo[0] = 1'b1;
        repeat (300) @(negedge clk);
        pulse_echo(1, 200);
        repeat (660) @(negedge clk);
        bus.echo[0] = 1'b0;
        wait_upd(20, "upd_ch0_basic");
        check("upd_ch_0", 32'(bus.upd_ch), 32'd0);
        check_near("dist0_580us", int'(bus.distance[15:0]), 100);
        check("valid_after_ch0", 32'(bus.valid), 32'd1);
        check("timeout_after_ch0", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        check("upd_stb_one_cycle", 32'(bus.upd_stb), 32'd0);

        // Slot ch1: slot period and 1160 us echo.
        wait_trig(1, 1'b1, 12000, "trig1_rise");
        t1 = cyc;
        check("slot_period", 32'(t1 - t0), 32'd10000);
        check("trig_onehot_ch1", 32'(bus.trig), 32'd2);
        wait_trig(1, 1'b0, 40, "trig1_fall");
        repeat (50) @(negedge clk);
        pulse_echo(1, 2320);
        wait_upd(20, "upd_ch1_basic");
        check("upd_ch_1", 32'(bus.upd_ch), 32'd1);
        check_near("dist1_1160us", int'(bus.distance[31:16]), 200);
        check("valid_both", 32'(bus.valid), 32'd3);

        // Slot ch0: 57 us echo rounds down to 9 mm.
        wait_trig(0, 1'b1, 12000, "trig0_rise_b");
        wait_trig(0, 1'b0, 40, "trig0_fall_b");
        repeat (50) @(negedge clk);
        pulse_echo(0, 114);
        wait_upd(20, "upd_ch0_57us");
        check_near("dist0_57us", int'(bus.distance[15:0]), 9);

        // Slot ch1: no echo; timeout fires 6000 cycles into WAIT_RISE, result one cycle later.
        wait_trig(1, 1'b1, 12000, "trig1_rise_b");
        wait_trig(1, 1'b0, 40, "trig1_fall_b");
        tw = cyc;
        wait_upd(7000, "upd_ch1_noecho");
        check("noecho_latency", 32'(cyc - tw), 32'd6001);
        check("noecho_upd_ch", 32'(bus.upd_ch), 32'd1);
        check("noecho_timeout", 32'(bus.timeout), 32'd2);
        check("noecho_valid", 32'(bus.valid), 32'd1);
        check("noecho_dist", 32'(bus.distance[31:16]), 32'hFFFF);

        // Slot ch0: echo held 4000 us; 3 sync cycles + 6000 cycles + 1 write cycle.
        wait_trig(0, 1'b1, 12000, "trig0_rise_c");
        wait_trig(0, 1'b0, 40, "trig0_fall_c");
        repeat (30) @(negedge clk);
        bus.echo[0] = 1'b1;
        tx = cyc;
        wait_upd(7000, "upd_ch0_long");
        check("long_latency", 32'(cyc - tx), 32'd6004);
        check("long_timeout", 32'(bus.timeout), 32'd3);
        check("long_valid", 32'(bus.valid), 32'd0);
        check("long_dist", 32'(bus.distance[15:0]), 32'hFFFF);
        repeat (8000 - (cyc - tx)) @(negedge clk);
        bus.echo[0] = 1'b0;

        // Slot ch1: 5 us echo gives 0 mm and clears the ch1 timeout.
        wait_trig(1, 1'b1, 12000, "trig1_rise_c");
        wait_trig(1, 1'b0, 40, "trig1_fall_c");
        repeat (50) @(negedge clk);
        pulse_echo(1, 10);
        wait_upd(20, "upd_ch1_5us");
        check_near("dist1_5us", int'(bus.distance[31:16]), 0);
        check("short_valid", 32'(bus.valid), 32'd2);
        check("short_timeout", 32'(bus.timeout), 32'd1);

        // Slot ch0: en dropped mid-measurement; result still lands, then scanning stops.
        wait_trig(0, 1'b1, 12000, "trig0_rise_d");
        wait_trig(0, 1'b0, 40, "trig0_fall_d");
        repeat (50) @(negedge clk);
        bus.echo[0] = 1'b1;
        repeat (500) @(negedge clk);
        bus.en = 1'b0;
        repeat (660) @(negedge clk);
        bus.echo[0] = 1'b0;
        wait_upd(20, "upd_ch0_endrop");
        check_near("endrop_dist0", int'(bus.distance[15:0]), 100);
        check("endrop_valid", 32'(bus.valid), 32'd3);
        check("endrop_timeout", 32'(bus.timeout), 32'd0);
        seen = 1'b0;
        repeat (12000) begin
            @(negedge clk);
            if (bus.trig !== '0) seen = 1'b1;
        end
        check("no_trig_disabled", 32'(seen), 32'd0);

        bus.en = 1'b1;
        wait_trig(1, 1'b1, 5, "resume_rise");
        check("resume_next_ch", 32'(bus.trig), 32'd2);

        // Reset during MEASURE clears results without waiting for a clock edge.
        wait_trig(1, 1'b0, 40, "trig1_fall_d");
        repeat (50) @(negedge clk);
        bus.echo[1] = 1'b1;
        repeat (200) @(negedge clk);
        check("pre_reset_valid", 32'(bus.valid), 32'd3);
        #20 rst = 1'b1;
        #1;
        check("rst_ctrl_async", 32'({bus.trig, bus.valid, bus.timeout, bus.upd_stb, bus.upd_ch}), 32'd0);
        check("rst_dist_async", 32'(bus.distance), 32'd0);
        repeat (3) @(negedge clk);
        bus.echo[1] = 1'b0;
        rst = 1'b0;
        wait_trig(0, 1'b1, 5, "restart_rise");
        check("restart_ch0", 32'(bus.trig), 32'd1);

        // Reset while trig is high drops it asynchronously.
        repeat (5) @(negedge clk);
        check("trig_high_before_rst", 32'(bus.trig), 32'd1);
        #20 rst = 1'b1;
        #1;
        check("trig_async_drop", 32'(bus.trig), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_trig(0, 1'b1, 5, "restart_rise_b");
        check("restart_ch0_b", 32'(bus.trig), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
